// File: rtl/cevero_bus_pkg.sv
// cevero_bus_pkg: shared response type, LFSR seed and address-range helper for the data responder
package cevero_bus_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Evaluated in 64 bits so base + 4*words can never wrap for any legal bus width
    function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base, input logic [63:0] words);
        return (addr >= base) && (addr < base + (words << 2));
    endfunction

endpackage

// File: rtl/cevero_resp_delay_line.sv
// cevero_resp_delay_line: LATENCY-deep shift register carrying {valid, resp_t}, synchronous active-low clear
module cevero_resp_delay_line
    import cevero_bus_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_valid,
    input  resp_t push_resp,
    output logic  pop_valid,
    output resp_t pop_resp
);

    logic [LATENCY-1:0]  valid_q;
    resp_t [LATENCY-1:0] resp_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            resp_q  <= '0;
        end else begin
            valid_q[0] <= push_valid;
            resp_q[0]  <= push_resp;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                resp_q[i]  <= resp_q[i-1];
            end
        end
    end

    assign pop_valid = valid_q[LATENCY-1];
    assign pop_resp  = resp_q[LATENCY-1];

endmodule

// File: rtl/cevero_data_responder.sv
// cevero_data_responder: req/gnt/rvalid word-memory responder with fixed response latency and bounded outstanding count.
// Defining CEVERO_RESP_STALL_INJECT_EN adds an LFSR that randomly withholds grants.
module cevero_data_responder
    import cevero_bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    NUM_WORDS       = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                    LATENCY         = 1,
    parameter int                    MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
);

    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [31:0]   mem [NUM_WORDS];
    logic [CW-1:0] cnt;
    logic          hit;
    logic          room;
    logic [IW-1:0] idx;
    resp_t         resp;
    resp_t         out;

    assign hit  = in_range(64'(addr_i), 64'(BASE_ADDR), 64'(NUM_WORDS));
    assign idx  = IW'((addr_i - BASE_ADDR) >> 2);
    assign room = cnt < MAX_CNT;

`ifdef CEVERO_RESP_STALL_INJECT_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk_i) begin
        lfsr <= !rst_ni ? LFSR_SEED : {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign gnt_o = req_i && room && !lfsr[0];
`else
    assign gnt_o = req_i && room;
`endif

    // Non-granted slots carry a zero response so idle outputs stay 0 without extra muxing
    assign resp.rdata = (gnt_o && hit && !we_i) ? mem[idx] : '0;
    assign resp.err   = gnt_o && !hit;

    always_ff @(posedge clk_i) begin
        if (gnt_o && we_i && hit) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt <= '0;
        else cnt <= cnt + CW'(gnt_o) - CW'(rvalid_o);
    end

    cevero_resp_delay_line #(
        .LATENCY(LATENCY)
    ) u_delay (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push_valid(gnt_o),
        .push_resp (resp),
        .pop_valid (rvalid_o),
        .pop_resp  (out)
    );

    assign rdata_o = out.rdata;
    assign err_o   = out.err;

endmodule

// File: tb/tb_cevero_data_responder.sv
// tb_cevero_data_responder: randomized bench against a queue-and-array reference model of the responder.
module tb_cevero_data_responder;

    localparam int LAT  = 3;
    localparam int MAXO = 2;
    localparam int NW   = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    always #5 clk = ~clk;

    cevero_data_responder #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .NUM_WORDS      (NW),
        .BASE_ADDR      (32'h0),
        .LATENCY        (LAT),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req),
        .gnt_o   (gnt),
        .addr_i  (addr),
        .we_i    (we),
        .be_i    (be),
        .wdata_i (wdata),
        .rvalid_o(rvalid),
        .rdata_o (rdata),
        .err_o   (err)
    );

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem [NW];
    logic [7:0]  lfsr = 8'hA5;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One bus cycle: drive, compare at negedge, update the model, advance past the next edge
    task automatic cycle(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic rs_n, output logic g);
        exp_t e;
        logic inr;
        req = r; we = w; addr = a; wdata = d; be = b; rst_n = rs_n;
        @(negedge clk);
        g = r && (q.size() < MAXO);
`ifdef CEVERO_RESP_STALL_INJECT_EN
        g = g && !lfsr[0];
`endif
        chk("gnt", 64'(gnt), 64'(g));
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rvalid", 64'(rvalid), 64'(1'b1));
            chk("rdata", 64'(rdata), 64'(q[0].rdata));
            chk("err", 64'(err), 64'(q[0].err));
            void'(q.pop_front());
        end else begin
            chk("rvalid_idle", 64'(rvalid), 64'(1'b0));
            chk("idle_data", 64'({rdata, err}), 64'(0));
        end
        if (g) begin
            inr = a < 32'(4 * NW);
            e.due = cyc + LAT;
            e.err = !inr;
            e.rdata = (inr && !w) ? mem[int'(a[9:2])] : 32'h0;
            if (inr && w) begin
                for (int k = 0; k < 4; k++) if (b[k]) mem[int'(a[9:2])][8*k +: 8] = d[8*k +: 8];
            end
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rs_n) begin
            q.delete();
            lfsr = 8'hA5;
        end else begin
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    endtask

    // Holds the request until the model says it is granted
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        logic g = 1'b0;
        for (int t = 0; t < 64 && !g; t++) cycle(1'b1, w, a, d, b, 1'b1, g);
        if (!g) chk("xfer_timeout", 64'(0), 64'(1));
    endtask

    task automatic idle(input int n);
        logic g;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, g);
    endtask

    initial begin
        logic        g;
        logic [31:0] a;
        int          sel;
        repeat (2) @(posedge clk);
        #1;
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, g);
        for (int i = 0; i < NW; i++) xfer(1'b1, 32'(i * 4), $urandom, 4'hF);
        idle(LAT + 1);
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        xfer(1'b0, 32'h10, 32'h0, 4'h0);
        xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF);
        xfer(1'b1, 32'h20, 32'h11223344, 4'b0101);
        xfer(1'b0, 32'h20, 32'h0, 4'h0);
        idle(LAT + 1);
        xfer(1'b0, 32'h400, 32'h0, 4'h0);
        xfer(1'b1, 32'h400, 32'h12345678, 4'hF);
        xfer(1'b1, 32'hFFFFFFFC, 32'h12345678, 4'hF);
        xfer(1'b0, 32'h0, 32'h0, 4'h0);
        xfer(1'b0, 32'h3FC, 32'h0, 4'h0);
        xfer(1'b1, 32'h30, 32'hCAFEF00D, 4'h0);
        xfer(1'b0, 32'h30, 32'h0, 4'h0);
        idle(LAT + 1);
        for (int i = 0; i < 6; i++) xfer(1'b0, 32'(i * 4), 32'h0, 4'h0);
        idle(LAT + 1);
        xfer(1'b0, 32'h10, 32'h0, 4'h0);
        xfer(1'b0, 32'h20, 32'h0, 4'h0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, g);
        idle(LAT);
        xfer(1'b0, 32'h10, 32'h0, 4'h0);
        idle(LAT + 1);
        for (int i = 0; i < 800; i++) begin
            sel = int'($urandom_range(0, 99));
            a = sel < 85 ? 32'($urandom_range(0, 63) * 4) :
                sel < 95 ? $urandom : (sel < 98 ? 32'h3FC : 32'h400);
            if ($urandom_range(0, 99) == 0) cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, g);
            else if ($urandom_range(0, 9) < 3) idle(1);
            else cycle(1'b1, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b1, g);
        end
        idle(LAT + 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
